handshake_coeff_sequencer: RTL and testbench
============================================

// Module: handshake_coeff_sequencer
// PURPOSE
//  Sequences the tanh soft-clip coefficient constants into the polynomial datapath, one token at a time.
//  Each accepted ctrl token carries a segment index; the block emits that segment's NUM_COEF coefficients
//  in order (c0..c3) as valid/ready tokens, marking the final beat with outs_last.
//  It is the scheduler that replaces the per-case handshake constants in the switch-case evaluator.
// PARAMETERS
//  DATA_WIDTH  8  coefficient width (two's complement, Q1.6)
//  NUM_SEG     4  number of piecewise segments (switch-case arms)
//  NUM_COEF    4  coefficients emitted per ctrl token
//  SEG_W       2  width of segment index = clog2(NUM_SEG)
// PORTS
//  clk         in   1           clock, all state on rising edge
//  rst         in   1           asynchronous, active-high reset
//  ctrl        in   SEG_W       segment index of the ctrl token
//  ctrl_valid  in   1           ctrl token valid
//  ctrl_ready  out  1           ctrl token accepted when valid&ready
//  outs        out  DATA_WIDTH  current coefficient
//  outs_valid  out  1           coefficient token valid
//  outs_ready  in   1           downstream accepts coefficient
//  outs_last   out  1           high on the final coefficient of a burst (qualified by outs_valid)
// BEHAVIOUR
//  - Reset (async, any cycle incl. mid-burst): state=IDLE, idx=0, seg_q=0; outs_valid=0, outs_last=0,
//    ctrl_ready=1 once rst deasserts; partially emitted burst is dropped, no resume.
//  - FSM: IDLE, EMIT. IDLE: outs_valid=0, ctrl_ready=1. ctrl_valid&ctrl_ready -> latch seg_q=ctrl, idx=0, go EMIT.
//  - EMIT: outs_valid=1, outs=COEF[seg_q][idx], outs_last=(idx==NUM_COEF-1).
//    outs_valid&outs_ready with idx<NUM_COEF-1 -> idx+1. On the last beat -> IDLE, idx=0.
//  - Back-to-back: ctrl_ready = IDLE | (EMIT & outs_last & outs_ready). If a ctrl token is taken on the
//    last beat, latch new seg_q, idx=0, stay EMIT (no bubble). Only combinational path is outs_ready->ctrl_ready.
//  - Latency: first coefficient valid the cycle after ctrl accept; burst of NUM_COEF beats at 1/cycle
//    with outs_ready=1; steady-state throughput one ctrl token per NUM_COEF cycles.
//  - Stall: outs_ready=0 holds outs, outs_valid, outs_last, idx stable (no token loss, no change while valid).
//  - ctrl is sampled only on handshake; ctrl changes while not accepted are ignored.
//  - Segment index >= NUM_SEG (only when NUM_SEG not a power of 2) is clamped to NUM_SEG-1 (saturation arm).
//  - outs is driven from registered seg_q/idx through the table (no data register); outs = 0 in IDLE.
//  - idx width clog2(NUM_COEF); no wrap beyond NUM_COEF-1 is reachable.
// STRUCTURE
//  - Package faust_softclip_pkg: DATA_WIDTH/NUM_SEG/NUM_COEF constants, state enum {IDLE,EMIT},
//    coefficient table COEF[NUM_SEG][NUM_COEF]:
//      seg0 {8'h00,8'h40,8'h00,8'hD5}  seg1 {8'h12,8'h38,8'hF0,8'h04}
//      seg2 {8'h3A,8'h10,8'hFC,8'h00}  seg3 {8'h40,8'h00,8'h00,8'h00}
//  - One sub-module: handshake_coeff_rom (combinational seg,idx -> coefficient lookup from package table).
//  - Top holds FSM, idx counter, seg_q register, handshake logic.
// TESTING
//  1. Reset then ctrl=0 valid 1 cycle, outs_ready=1 -> outs 00,40,00,D5 on 4 consecutive cycles from
//     cycle+1, outs_last only with D5, ctrl_ready=0 during beats 1-3.
//  2. ctrl=1 then ctrl=2 held valid, outs_ready=1 -> 12,38,F0,04,3A,10,FC,00 with no bubble; ctrl_ready
//     high on the 04 beat; outs_last on 04 and 00.
//  3. ctrl=2, outs_ready toggled 1,0,0,1,1,0,1 -> outs holds value while ready=0; sequence 3A,10,FC,00
//     delivered exactly once each.
//  4. rst asserted mid-burst after c1 of seg3 -> outs_valid=0 same cycle (async); next ctrl=0 restarts at 00.
//  5. ctrl=3 with outs_ready=0 for 10 cycles -> outs=40, outs_valid=1, outs_last=0 stable; ctrl_ready=0;
//     ctrl input changes ignored.
//  6. Random ctrl/valid/ready traffic vs scoreboard model of COEF table -> zero mismatches, last every 4th beat.

Source files
------------

// File: rtl/faust_softclip_pkg.sv
// faust_softclip_pkg: shared sizes, FSM state type and tanh soft-clip coefficient table.
//   DATA_WIDTH  coefficient width (Q1.6 two's complement)
//   NUM_SEG     piecewise segments, SEG_W bits of index
//   NUM_COEF    coefficients per segment, IDX_W bits of index
//   COEF        [segment][coefficient] table, c0 first
package faust_softclip_pkg;
   localparam int DATA_WIDTH = 8;
   localparam int NUM_SEG    = 4;
   localparam int NUM_COEF   = 4;
   localparam int SEG_W      = $clog2(NUM_SEG);
   localparam int IDX_W      = $clog2(NUM_COEF);
   typedef enum logic {IDLE, EMIT} state_t;
   localparam logic [DATA_WIDTH-1:0] COEF [NUM_SEG][NUM_COEF] = '{
      '{8'h00, 8'h40, 8'h00, 8'hD5},
      '{8'h12, 8'h38, 8'hF0, 8'h04},
      '{8'h3A, 8'h10, 8'hFC, 8'h00},
      '{8'h40, 8'h00, 8'h00, 8'h00}
   };
endpackage

// File: rtl/handshake_coeff_rom.sv
// handshake_coeff_rom: combinational coefficient lookup.
//   seg   in   segment index (out-of-range values saturate to the last segment)
//   idx   in   coefficient index within the segment
//   coef  out  COEF[seg][idx]
module handshake_coeff_rom
   import faust_softclip_pkg::*;
(
   input  logic [SEG_W-1:0]      seg,
   input  logic [IDX_W-1:0]      idx,
   output logic [DATA_WIDTH-1:0] coef
);
   logic [SEG_W-1:0] seg_c;
   // Saturation only exists when the index width can express missing segments.
   if ((1 << SEG_W) == NUM_SEG) begin : g_full
      assign seg_c = seg;
   end else begin : g_clamp
      assign seg_c = (seg >= SEG_W'(NUM_SEG - 1)) ? SEG_W'(NUM_SEG - 1) : seg;
   end
   assign coef = COEF[seg_c][idx];
endmodule

// File: rtl/handshake_coeff_sequencer.sv
// handshake_coeff_sequencer: turns each ctrl segment token into a NUM_COEF-beat coefficient burst.
//   clk, rst     clock, asynchronous active-high reset
//   ctrl         segment index, sampled on ctrl_valid & ctrl_ready
//   ctrl_valid   ctrl token valid
//   ctrl_ready   ctrl token accepted (idle, or last beat being consumed)
//   outs         current coefficient, 0 when idle
//   outs_valid   coefficient token valid
//   outs_ready   downstream accepts coefficient
//   outs_last    final coefficient of the burst
module handshake_coeff_sequencer
   import faust_softclip_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [SEG_W-1:0]      ctrl,
   input  logic                  ctrl_valid,
   output logic                  ctrl_ready,
   output logic [DATA_WIDTH-1:0] outs,
   output logic                  outs_valid,
   input  logic                  outs_ready,
   output logic                  outs_last
);
   state_t           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [SEG_W-1:0] seg_q, seg_d;
   logic [DATA_WIDTH-1:0] coef;
   handshake_coeff_rom u_rom (
      .seg  (seg_q),
      .idx  (idx_q),
      .coef (coef)
   );
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         seg_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         seg_q   <= seg_d;
      end
   end
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      seg_d      = seg_q;
      outs_valid = state_q == EMIT;
      outs_last  = outs_valid && idx_q == IDX_W'(NUM_COEF - 1);
      outs       = outs_valid ? coef : '0;
      // Accepting on the last beat lets the next burst follow with no bubble.
      ctrl_ready = !outs_valid || (outs_last && outs_ready);
      if (outs_valid && outs_ready) begin
         idx_d   = outs_last ? '0 : idx_q + 1'b1;
         state_d = outs_last ? IDLE : EMIT;
      end
      if (ctrl_valid && ctrl_ready) begin
         seg_d   = ctrl;
         idx_d   = '0;
         state_d = EMIT;
      end
   end
endmodule

// File: tb/tb_handshake_coeff_sequencer.sv
// tb_handshake_coeff_sequencer: scoreboard bench for the coefficient sequencer.
module tb_handshake_coeff_sequencer;
   localparam logic [7:0] TBL [4][4] = '{
      '{8'h00, 8'h40, 8'h00, 8'hD5},
      '{8'h12, 8'h38, 8'hF0, 8'h04},
      '{8'h3A, 8'h10, 8'hFC, 8'h00},
      '{8'h40, 8'h00, 8'h00, 8'h00}
   };
   logic       clk = 0;
   logic       rst = 1;
   logic [1:0] ctrl = 0;
   logic       ctrl_valid = 0;
   logic       ctrl_ready;
   logic [7:0] outs;
   logic       outs_valid;
   logic       outs_ready = 0;
   logic       outs_last;
   logic [8:0] q[$];
   logic       e_v, e_l, e_r;
   logic [7:0] e_d;
   int         checks = 0;
   int         failures = 0;
   int         beats;
   int         acc;
   always #5 clk = ~clk;
   handshake_coeff_sequencer dut (
      .clk        (clk),
      .rst        (rst),
      .ctrl       (ctrl),
      .ctrl_valid (ctrl_valid),
      .ctrl_ready (ctrl_ready),
      .outs       (outs),
      .outs_valid (outs_valid),
      .outs_ready (outs_ready),
      .outs_last  (outs_last)
   );
   task automatic test_reset();
      rst = 1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({outs_valid, outs_last, outs} !== 10'b0) begin
         failures++;
         $display("FAIL reset_outputs got v=%b l=%b d=%h exp 0 0 00", outs_valid, outs_last, outs);
      end
      rst = 0;
      q.delete();
      @(negedge clk);
      checks++;
      if (ctrl_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_ctrl_ready got %b exp 1", ctrl_ready);
      end
      @(posedge clk);
      #1;
   endtask
   task automatic test_single();
      for (int i = 0; i < 6; i++) begin
         ctrl = 0;
         ctrl_valid = i == 0;
         outs_ready = 1;
         @(negedge clk);
         e_v = q.size() != 0;
         e_d = e_v ? q[0][7:0] : 8'h00;
         e_l = e_v && q[0][8];
         e_r = !e_v || (e_l && outs_ready);
         checks++;
         if ({outs_valid, outs_last, outs, ctrl_ready} !== {e_v, e_l, e_d, e_r}) begin
            failures++;
            $display("FAIL single[%0d] v/l/d/rdy got %b %b %h %b exp %b %b %h %b", i, outs_valid, outs_last, outs, ctrl_ready, e_v, e_l, e_d, e_r);
         end
         if (e_v && outs_ready) void'(q.pop_front());
         if (ctrl_valid && e_r) for (int k = 0; k < 4; k++) q.push_back({k == 3, TBL[ctrl][k]});
         @(posedge clk);
         #1;
      end
      ctrl_valid = 0;
   endtask
   task automatic test_back_to_back();
      acc = 0;
      for (int i = 0; i < 11; i++) begin
         ctrl = acc == 0 ? 2'd1 : 2'd2;
         ctrl_valid = acc < 2;
         outs_ready = 1;
         @(negedge clk);
         e_v = q.size() != 0;
         e_d = e_v ? q[0][7:0] : 8'h00;
         e_l = e_v && q[0][8];
         e_r = !e_v || (e_l && outs_ready);
         checks++;
         if ({outs_valid, outs_last, outs, ctrl_ready} !== {e_v, e_l, e_d, e_r}) begin
            failures++;
            $display("FAIL b2b[%0d] v/l/d/rdy got %b %b %h %b exp %b %b %h %b", i, outs_valid, outs_last, outs, ctrl_ready, e_v, e_l, e_d, e_r);
         end
         if (e_v && outs_ready) void'(q.pop_front());
         if (ctrl_valid && e_r) begin
            for (int k = 0; k < 4; k++) q.push_back({k == 3, TBL[ctrl][k]});
            acc++;
         end
         @(posedge clk);
         #1;
      end
      ctrl_valid = 0;
   endtask
   task automatic test_stall();
      logic [6:0] pat = 7'b1011001;
      beats = 0;
      for (int i = 0; i < 10; i++) begin
         ctrl = 2;
         ctrl_valid = i == 0;
         outs_ready = (i >= 1 && i <= 7) ? pat[i-1] : 1'b1;
         @(negedge clk);
         e_v = q.size() != 0;
         e_d = e_v ? q[0][7:0] : 8'h00;
         e_l = e_v && q[0][8];
         e_r = !e_v || (e_l && outs_ready);
         checks++;
         if ({outs_valid, outs_last, outs, ctrl_ready} !== {e_v, e_l, e_d, e_r}) begin
            failures++;
            $display("FAIL stall[%0d] v/l/d/rdy got %b %b %h %b exp %b %b %h %b", i, outs_valid, outs_last, outs, ctrl_ready, e_v, e_l, e_d, e_r);
         end
         if (e_v && outs_ready) begin
            void'(q.pop_front());
            beats++;
         end
         if (ctrl_valid && e_r) for (int k = 0; k < 4; k++) q.push_back({k == 3, TBL[ctrl][k]});
         @(posedge clk);
         #1;
      end
      ctrl_valid = 0;
      checks++;
      if (beats != 4 || q.size() != 0) begin
         failures++;
         $display("FAIL stall_delivery got beats=%0d left=%0d exp 4 0", beats, q.size());
      end
   endtask
   task automatic test_mid_reset();
      for (int i = 0; i < 3; i++) begin
         ctrl = 3;
         ctrl_valid = i == 0;
         outs_ready = 1;
         @(negedge clk);
         e_v = q.size() != 0;
         e_d = e_v ? q[0][7:0] : 8'h00;
         e_l = e_v && q[0][8];
         e_r = !e_v || (e_l && outs_ready);
         checks++;
         if ({outs_valid, outs_last, outs, ctrl_ready} !== {e_v, e_l, e_d, e_r}) begin
            failures++;
            $display("FAIL midrst[%0d] v/l/d/rdy got %b %b %h %b exp %b %b %h %b", i, outs_valid, outs_last, outs, ctrl_ready, e_v, e_l, e_d, e_r);
         end
         if (e_v && outs_ready) void'(q.pop_front());
         if (ctrl_valid && e_r) for (int k = 0; k < 4; k++) q.push_back({k == 3, TBL[ctrl][k]});
         @(posedge clk);
         #1;
      end
      ctrl_valid = 0;
      checks++;
      if (outs_valid !== 1'b1 || outs !== 8'h00) begin
         failures++;
         $display("FAIL midrst_pre got v=%b d=%h exp 1 00", outs_valid, outs);
      end
      #1 rst = 1;
      #1;
      checks++;
      if ({outs_valid, outs_last, outs} !== 10'b0) begin
         failures++;
         $display("FAIL midrst_async got v=%b l=%b d=%h exp 0 0 00", outs_valid, outs_last, outs);
      end
      #1 rst = 0;
      q.delete();
      @(posedge clk);
      #1;
      test_single();
   endtask
   task automatic test_hold();
      for (int i = 0; i < 16; i++) begin
         ctrl = i == 0 ? 2'd3 : 2'($urandom_range(0, 3));
         ctrl_valid = i <= 10;
         outs_ready = i > 10;
         @(negedge clk);
         e_v = q.size() != 0;
         e_d = e_v ? q[0][7:0] : 8'h00;
         e_l = e_v && q[0][8];
         e_r = !e_v || (e_l && outs_ready);
         checks++;
         if ({outs_valid, outs_last, outs, ctrl_ready} !== {e_v, e_l, e_d, e_r}) begin
            failures++;
            $display("FAIL hold[%0d] v/l/d/rdy got %b %b %h %b exp %b %b %h %b", i, outs_valid, outs_last, outs, ctrl_ready, e_v, e_l, e_d, e_r);
         end
         if (e_v && outs_ready) void'(q.pop_front());
         if (ctrl_valid && e_r) for (int k = 0; k < 4; k++) q.push_back({k == 3, TBL[ctrl][k]});
         @(posedge clk);
         #1;
      end
      ctrl_valid = 0;
   endtask
   task automatic test_random();
      beats = 0;
      for (int i = 0; i < 400; i++) begin
         ctrl = 2'($urandom_range(0, 3));
         ctrl_valid = i < 390 && ($urandom_range(0, 2) != 0);
         outs_ready = i >= 390 || ($urandom_range(0, 3) != 0);
         @(negedge clk);
         e_v = q.size() != 0;
         e_d = e_v ? q[0][7:0] : 8'h00;
         e_l = e_v && q[0][8];
         e_r = !e_v || (e_l && outs_ready);
         checks++;
         if ({outs_valid, outs_last, outs, ctrl_ready} !== {e_v, e_l, e_d, e_r}) begin
            failures++;
            $display("FAIL random[%0d] v/l/d/rdy got %b %b %h %b exp %b %b %h %b", i, outs_valid, outs_last, outs, ctrl_ready, e_v, e_l, e_d, e_r);
         end
         if (e_v && outs_ready) begin
            void'(q.pop_front());
            beats++;
         end
         if (ctrl_valid && e_r) for (int k = 0; k < 4; k++) q.push_back({k == 3, TBL[ctrl][k]});
         @(posedge clk);
         #1;
      end
      ctrl_valid = 0;
      checks++;
      if (beats % 4 != 0 || beats == 0 || q.size() != 0) begin
         failures++;
         $display("FAIL random_drain got beats=%0d left=%0d exp multiple of 4, 0 left", beats, q.size());
      end
   endtask
   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_stall();
      test_mid_reset();
      test_hold();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
